multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for a multicycle RV32I-subset datapath (lw, sw, R-type ALU,
// I-type ALU, beq, jal). A Moore-style main FSM steps through each
// instruction. Alongside it sit two small combinational decoders: one picks
// the immediate format from the opcode, the other turns the internal ALU
// operation class into an ALU control code.
//
// Memory handshake: mem_ready is sampled in FETCH, MEMREAD and MEMWRITE.
// A memory access completes in the cycle where mem_ready=1. Until then the
// FSM holds its state and keeps the access-related controls stable. IRWrite
// and PCWrite in FETCH fire only in the completing cycle. MemWrite stays
// high for the whole MEMWRITE wait, including the completing cycle.
//
// Ports
//   clk           : clock, rising edge active
//   rst_n         : synchronous active-low reset
//   op            : instruction[6:0]
//   funct3        : instruction[14:12]
//   funct7b5      : instruction[30]
//   zero          : ALU zero flag (branch condition)
//   mem_ready     : memory completes the current access this cycle
//   PCWrite       : PC register write enable
//   AdrSrc        : memory address select (0 = PC, 1 = ALU result)
//   IRWrite       : instruction register write enable
//   MemWrite      : data memory write enable
//   RegWrite      : register file write enable
//   ResultSrc     : result mux select (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUSrcA       : ALU A mux select (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB       : ALU B mux select (00 rs2, 01 imm, 10 constant 4)
//   ImmSrc        : immediate format select
//   ALUControl    : ALU operation code
//   illegal_instr : one-cycle pulse when DECODE sees an unsupported opcode
//   state         : current FSM state, for debug
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter logic [1:0] I_TYPE = 2'b00,
    parameter logic [1:0] S_TYPE = 2'b01,
    parameter logic [1:0] B_TYPE = 2'b10,
    parameter logic [1:0] J_TYPE = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_instr,
    output logic [3:0] state
);

    // ------------------------------------------------------------------
    // Opcodes recognised by the decoder
    // ------------------------------------------------------------------
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ------------------------------------------------------------------
    // FSM state encoding (the codes are visible on the debug port)
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // ALU operation class chosen by the FSM, resolved by the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state_q;
    state_t state_d;
    aluop_t alu_op;

    // Raw write enables before reset gating.
    logic pc_write_raw;
    logic ir_write_raw;
    logic mem_write_raw;
    logic reg_write_raw;
    logic illegal_raw;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER, S_EXECUTEI: begin
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                state_d = S_FETCH;
            end
            S_BEQ: begin
                state_d = S_FETCH;
            end
            S_JAL: begin
                state_d = S_ALUWB;
            end
            // Unused encodings 11..15 recover to FETCH.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-state datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                // PC + 4 computed while the instruction is read. The
                // IR and PC are committed only when memory delivers.
                AdrSrc       = 1'b0;
                ALUSrcA      = 2'b00;
                ALUSrcB      = 2'b10;
                alu_op       = ALUOP_ADD;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                // Precompute OldPC + imm (branch/jump target).
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL:
                        illegal_raw = 1'b0;
                    default:
                        illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_ADD;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = 2'b00;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                // Write strobe held for the whole access, including the
                // cycle in which memory signals completion.
                AdrSrc        = 1'b1;
                ResultSrc     = 2'b00;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc     = 2'b00;
                reg_write_raw = 1'b1;
            end
            S_BEQ: begin
                // rs1 - rs2; the target computed in DECODE sits in ALUOut.
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b00;
                alu_op       = ALUOP_SUB;
                ResultSrc    = 2'b00;
                pc_write_raw = zero;
            end
            S_JAL: begin
                // Loads the target from ALUOut while computing the link
                // address OldPC + 4 for the ALUWB that follows.
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                alu_op       = ALUOP_ADD;
                ResultSrc    = 2'b00;
                pc_write_raw = 1'b1;
            end
            default: begin
                // Unused encodings drive everything low.
                alu_op = ALUOP_ADD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Reset gating: no architectural write can escape while rst_n is low,
    // whatever state the register still holds during that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite       = pc_write_raw  & rst_n;
        IRWrite       = ir_write_raw  & rst_n;
        MemWrite      = mem_write_raw & rst_n;
        RegWrite      = reg_write_raw & rst_n;
        illegal_instr = illegal_raw   & rst_n;
    end

    // ------------------------------------------------------------------
    // Immediate format decoder (opcode only, independent of state)
    // ------------------------------------------------------------------
    always_comb begin
        ImmSrc = I_TYPE;
        case (op)
            OP_LW, OP_ITYPE: ImmSrc = I_TYPE;
            OP_SW:           ImmSrc = S_TYPE;
            OP_BEQ:          ImmSrc = B_TYPE;
            OP_JAL:          ImmSrc = J_TYPE;
            default:         ImmSrc = I_TYPE;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) with funct7[5]=1 is sub.
                    // addi ignores instruction bit 30 because it is
                    // part of the immediate.
                    3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed, table-driven check of multicycle_controller. Each table row
// holds the inputs for one clock cycle and the expected values of every
// output in that cycle. Rows are applied back to back, so consecutive rows
// form whole instructions. A hand-written loop then measures per-instruction
// cycle counts with memory always ready.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BQ   = 7'b1100011;
    localparam logic [6:0] JL   = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b1111111;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal_instr;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .IRWrite      (IRWrite),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ImmSrc       (ImmSrc),
        .ALUControl   (ALUControl),
        .illegal_instr(illegal_instr),
        .state        (state)
    );

    // Output bundle layout:
    // {state, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
    //  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr}
    typedef struct {
        string      nm;
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       mr;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t v(
        input string nm, input logic rst, input logic [6:0] o, input logic [2:0] f3,
        input logic f7, input logic z, input logic mr, input logic [3:0] st,
        input logic pcw, input logic adr, input logic irw, input logic mw, input logic rw,
        input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
        input logic [1:0] imm, input logic [2:0] alu, input logic ill);
        vec_t t;
        t.nm  = nm;
        t.rst = rst;
        t.op  = o;
        t.f3  = f3;
        t.f7  = f7;
        t.z   = z;
        t.mr  = mr;
        t.exp = {st, pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, ill};
        return t;
    endfunction

    function automatic logic [20:0] actual();
        return {state, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input vec_t t, input int idx);
        logic [20:0] act;
        rst_n     = t.rst;
        op        = t.op;
        funct3    = t.f3;
        funct7b5  = t.f7;
        zero      = t.z;
        mem_ready = t.mr;
        #1;
        act = actual();
        n_checks++;
        if (act === t.exp) begin
            n_pass++;
        end else begin
            $display("FAIL row%0d %s: got %06h expected %06h", idx, t.nm, act, t.exp);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    task automatic build_table();
        // reset held with memory ready: FETCH selects, enables forced low
        vecs.push_back(v("rst_fetch", 0, LW, 3'd0, 0, 0, 1, 4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        // lw, memory always ready
        vecs.push_back(v("lw_fetch",  1, LW, 3'd0, 0, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(v("lw_decode", 1, LW, 3'd0, 0, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(v("lw_memadr", 1, LW, 3'd0, 0, 0, 1, 4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000,0));
        vecs.push_back(v("lw_memrd",  1, LW, 3'd0, 0, 0, 1, 4'd3, 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        vecs.push_back(v("lw_memwb",  1, LW, 3'd0, 0, 0, 1, 4'd4, 0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,3'b000,0));
        // sw with two wait cycles in MEMWRITE
        vecs.push_back(v("sw_fetch",  1, SW, 3'd2, 0, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0));
        vecs.push_back(v("sw_decode", 1, SW, 3'd2, 0, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01,3'b000,0));
        vecs.push_back(v("sw_memadr", 1, SW, 3'd2, 0, 0, 1, 4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01,3'b000,0));
        vecs.push_back(v("sw_wait1",  1, SW, 3'd2, 0, 0, 0, 4'd5, 0,1,0,1,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0));
        vecs.push_back(v("sw_wait2",  1, SW, 3'd2, 0, 0, 0, 4'd5, 0,1,0,1,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0));
        vecs.push_back(v("sw_done",   1, SW, 3'd2, 0, 0, 1, 4'd5, 0,1,0,1,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0));
        // R-type sub
        vecs.push_back(v("sub_fetch", 1, RT, 3'd0, 1, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(v("sub_dec",   1, RT, 3'd0, 1, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(v("sub_exe",   1, RT, 3'd0, 1, 0, 1, 4'd6, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b001,0));
        vecs.push_back(v("sub_wb",    1, RT, 3'd0, 1, 0, 1, 4'd8, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        // addi with instruction bit 30 set: still add
        vecs.push_back(v("addi_fetch",1, IT, 3'd0, 1, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(v("addi_dec",  1, IT, 3'd0, 1, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(v("addi_exe",  1, IT, 3'd0, 1, 0, 1, 4'd7, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000,0));
        vecs.push_back(v("addi_wb",   1, IT, 3'd0, 1, 0, 1, 4'd8, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        // slti
        vecs.push_back(v("slti_fetch",1, IT, 3'd2, 0, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(v("slti_dec",  1, IT, 3'd2, 0, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(v("slti_exe",  1, IT, 3'd2, 0, 0, 1, 4'd7, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b101,0));
        vecs.push_back(v("slti_wb",   1, IT, 3'd2, 0, 0, 1, 4'd8, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        // R-type or
        vecs.push_back(v("or_fetch",  1, RT, 3'd6, 0, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(v("or_dec",    1, RT, 3'd6, 0, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(v("or_exe",    1, RT, 3'd6, 0, 0, 1, 4'd6, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b011,0));
        vecs.push_back(v("or_wb",     1, RT, 3'd6, 0, 0, 1, 4'd8, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        // R-type and
        vecs.push_back(v("and_fetch", 1, RT, 3'd7, 0, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(v("and_dec",   1, RT, 3'd7, 0, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(v("and_exe",   1, RT, 3'd7, 0, 0, 1, 4'd6, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b010,0));
        vecs.push_back(v("and_wb",    1, RT, 3'd7, 0, 0, 1, 4'd8, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        // beq taken
        vecs.push_back(v("beq1_fetch",1, BQ, 3'd0, 0, 1, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b10,3'b000,0));
        vecs.push_back(v("beq1_dec",  1, BQ, 3'd0, 0, 1, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000,0));
        vecs.push_back(v("beq1_br",   1, BQ, 3'd0, 0, 1, 1, 4'd9, 1,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b001,0));
        // beq not taken
        vecs.push_back(v("beq0_fetch",1, BQ, 3'd0, 0, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b10,3'b000,0));
        vecs.push_back(v("beq0_dec",  1, BQ, 3'd0, 0, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000,0));
        vecs.push_back(v("beq0_br",   1, BQ, 3'd0, 0, 0, 1, 4'd9, 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b001,0));
        // jal
        vecs.push_back(v("jal_fetch", 1, JL, 3'd0, 0, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b11,3'b000,0));
        vecs.push_back(v("jal_dec",   1, JL, 3'd0, 0, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b11,3'b000,0));
        vecs.push_back(v("jal_jump",  1, JL, 3'd0, 0, 0, 1, 4'd10,1,0,0,0,0, 2'b00,2'b01,2'b10,2'b11,3'b000,0));
        vecs.push_back(v("jal_wb",    1, JL, 3'd0, 0, 0, 1, 4'd8, 0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11,3'b000,0));
        // fetch stalled three cycles, then an unsupported opcode
        vecs.push_back(v("stall1",    1, BAD,3'd0, 0, 0, 0, 4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(v("stall2",    1, BAD,3'd0, 0, 0, 0, 4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(v("stall3",    1, BAD,3'd0, 0, 0, 0, 4'd0, 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(v("stall_go",  1, BAD,3'd0, 0, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(v("illegal",   1, BAD,3'd0, 0, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,1));
        // reset during a pending MEMWRITE
        vecs.push_back(v("swr_fetch", 1, SW, 3'd2, 0, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0));
        vecs.push_back(v("swr_dec",   1, SW, 3'd2, 0, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01,3'b000,0));
        vecs.push_back(v("swr_memadr",1, SW, 3'd2, 0, 0, 1, 4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01,3'b000,0));
        vecs.push_back(v("swr_wait",  1, SW, 3'd2, 0, 0, 0, 4'd5, 0,1,0,1,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0));
        vecs.push_back(v("swr_reset", 0, SW, 3'd2, 0, 0, 0, 4'd5, 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0));
        vecs.push_back(v("post_rst_f",1, SW, 3'd2, 0, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0));
        // finish that sw normally so the next sequence starts in FETCH
        vecs.push_back(v("post_rst_d",1, SW, 3'd2, 0, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01,3'b000,0));
        vecs.push_back(v("post_rst_a",1, SW, 3'd2, 0, 0, 1, 4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01,3'b000,0));
        vecs.push_back(v("post_rst_w",1, SW, 3'd2, 0, 0, 1, 4'd5, 0,1,0,1,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0));
        // lw with one wait cycle in MEMREAD
        vecs.push_back(v("lwr_fetch", 1, LW, 3'd2, 0, 0, 1, 4'd0, 1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0));
        vecs.push_back(v("lwr_dec",   1, LW, 3'd2, 0, 0, 1, 4'd1, 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0));
        vecs.push_back(v("lwr_memadr",1, LW, 3'd2, 0, 0, 1, 4'd2, 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000,0));
        vecs.push_back(v("lwr_wait",  1, LW, 3'd2, 0, 0, 0, 4'd3, 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        vecs.push_back(v("lwr_done",  1, LW, 3'd2, 0, 0, 1, 4'd3, 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0));
        vecs.push_back(v("lwr_wb",    1, LW, 3'd2, 0, 0, 1, 4'd4, 0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,3'b000,0));
    endtask

    // ---------------- cycle-count sequence ----------------
    // Starting in FETCH with memory always ready, count cycles until the
    // FSM is back in FETCH.
    task automatic count_cycles(input string nm, input logic [6:0] o, input int exp_cycles);
        int cycles;
        rst_n     = 1'b1;
        op        = o;
        funct3    = 3'd0;
        funct7b5  = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        cycles    = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (state !== 4'd0 && cycles < 20);
        n_checks++;
        if (cycles == exp_cycles && state === 4'd0) begin
            n_pass++;
        end else begin
            $display("FAIL cycles_%s: got %0d cycles (state %0d) expected %0d", nm, cycles, state, exp_cycles);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        rst_n     = 1'b0;
        op        = LW;
        funct3    = 3'd0;
        funct7b5  = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        build_table();
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        count_cycles("lw",   LW, 5);
        count_cycles("sw",   SW, 4);
        count_cycles("rtype",RT, 4);
        count_cycles("itype",IT, 4);
        count_cycles("beq",  BQ, 3);
        count_cycles("jal",  JL, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
